fifo_ext: RTL

Synchronous single-clock FIFO with non-power-of-two depth support, optional fall-through (first-word bypass) mode, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It extends the basic synchronous FIFO with correct simultaneous push/pop accounting. It is intended as the standard buffering element between IP datapaths, for example UART/SPI RX/TX queues and bus response buffers, where software-programmable watermarks drive interrupts.

---
 rtl/fifo_ext_if.sv | 40 ++++
 rtl/fifo_ext.sv | 109 ++++++++++
 2 files changed

// File: rtl/fifo_ext_if.sv
// fifo_ext_if: handshake, data, watermark and error signals of one fifo_ext.
//   slave  modport: the FIFO itself (requests and thresholds in, status out).
//   master modport: the producer/consumer side driving the FIFO.
// CNT_WIDTH must equal $clog2(BUFFER_DEPTH+1) of the attached fifo_ext.
//
// Handshake semantics: a push is accepted on a rising clock edge when
// push_i=1, full_o=0 and flush_i=0. A pop is accepted on a rising edge when
// pop_i=1, empty_o=0 and flush_i=0. full_o/empty_o act as the ready signals
// and are never combinationally dependent on push_i/pop_i. A request that is
// not accepted is dropped (not held) and only raises the sticky error flag.
interface fifo_ext_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic                  flush_i;
  logic                  push_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  full_o;
  logic                  pop_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  empty_o;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic [CNT_WIDTH-1:0]  afull_thr_i;
  logic [CNT_WIDTH-1:0]  aempty_thr_i;
  logic                  afull_o;
  logic                  aempty_o;
  logic                  err_clr_i;
  logic                  ovf_o;
  logic                  udf_o;

  modport slave (
    input  flush_i, push_i, dat_i, pop_i, afull_thr_i, aempty_thr_i, err_clr_i,
    output full_o, dat_o, empty_o, cnt_o, afull_o, aempty_o, ovf_o, udf_o
  );

  modport master (
    output flush_i, push_i, dat_i, pop_i, afull_thr_i, aempty_thr_i, err_clr_i,
    input  full_o, dat_o, empty_o, cnt_o, afull_o, aempty_o, ovf_o, udf_o
  );
endinterface

// File: rtl/fifo_ext.sv
// fifo_ext: synchronous single-clock FIFO with any depth >= 2, optional
// fall-through bypass, almost-full/almost-empty watermarks and sticky
// overflow/underflow flags.
// Ports:
//   clk_i   - clock, all state updates on the rising edge
//   rst_n_i - synchronous active-low reset (clears pointers, count, memory,
//             error flags)
//   bus     - fifo_ext_if.slave: flush/push/pop requests, data in/out,
//             occupancy, full/empty, watermark flags, error flags and clear
module fifo_ext #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int FALL_THROUGH = 0,
  localparam int PTR_WIDTH   = $clog2(BUFFER_DEPTH),
  localparam int CNT_WIDTH   = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  fifo_ext_if.slave   bus
);

  localparam bit                   FT_EN     = (FALL_THROUGH != 0);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(BUFFER_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  ovf;
  logic                  udf;

  logic full;
  logic empty;
  logic push_hs;
  logic pop_hs;
  logic bypass;
  logic wr_en;
  logic ovf_set;
  logic udf_set;

  // Depth need not be a power of two, so wrap by compare instead of overflow.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign full  = (cnt == DEPTH_CNT);
  assign empty = (cnt == '0);

  assign push_hs = bus.push_i & ~full & ~bus.flush_i;
  assign pop_hs  = bus.pop_i & ~empty & ~bus.flush_i;
  // Bypass only happens when empty, so pop_hs is already 0 in that case.
  assign bypass  = FT_EN & empty & bus.push_i & bus.pop_i & ~bus.flush_i;
  assign wr_en   = push_hs & ~bypass;

  assign ovf_set = bus.push_i & full & ~bus.flush_i;
  assign udf_set = bus.pop_i & empty & ~bypass & ~bus.flush_i;

  always_comb begin
    cnt_nxt = cnt;
    unique case ({wr_en, pop_hs})
      2'b10:   cnt_nxt = cnt + CNT_WIDTH'(1);
      2'b01:   cnt_nxt = cnt - CNT_WIDTH'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // A new error in the same cycle as the clear keeps the flag set.
      ovf <= ovf_set | (ovf & ~bus.err_clr_i);
      udf <= udf_set | (udf & ~bus.err_clr_i);
      if (bus.flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en) begin
          mem[wr_ptr] <= bus.dat_i;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop_hs) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        cnt <= cnt_nxt;
      end
    end
  end

  assign bus.dat_o    = bypass ? bus.dat_i : mem[rd_ptr];
  assign bus.full_o   = full;
  assign bus.empty_o  = empty;
  assign bus.cnt_o    = cnt;
  assign bus.afull_o  = (cnt >= bus.afull_thr_i);
  assign bus.aempty_o = (cnt <= bus.aempty_thr_i);
  assign bus.ovf_o    = ovf;
  assign bus.udf_o    = udf;

endmodule
